// File: rtl/design_sel_pkg.sv
// Shared types for the design-select controller.
// Optional even-parity framing is enabled by DES_SEL_PARITY_EN.
package design_sel_pkg;

  typedef enum logic [1:0] {
    RST_HOLD,
    SETTLE,
    RUN
  } state_e;

  localparam int unsigned DEF_SEL_W = 6;
  localparam int unsigned FRAME_W   = DEF_SEL_W + 1;

  typedef struct packed {
    logic                 hold;
    logic [DEF_SEL_W-1:0] sel;
  } frame_t;

  // Serial frame length in bits for a given select width.
  function automatic int unsigned frame_len(input int unsigned sel_w);
`ifdef DES_SEL_PARITY_EN
    return sel_w + 2;
`else
    return sel_w + 1;
`endif
  endfunction

endpackage

// File: rtl/design_sel_ctrl_cfg_shift_rx.sv
// Serial config receiver: shift register, bit count, frame-end detect.
// With DES_SEL_PARITY_EN the last bit is even parity over the frame.
module cfg_shift_rx
  import design_sel_pkg::*;
#(
  parameter int unsigned SEL_W = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run_i,
  input  logic           cfg_en_i,
  input  logic           cfg_data_i,
  output logic           frame_valid_o,
  output logic           frame_bad_o,
  output logic [SEL_W:0] frame_o
);

  localparam int unsigned LEN = frame_len(SEL_W);
  localparam int unsigned CW  = $clog2(LEN + 2);

  logic [LEN-1:0] sr_q;
  logic [CW-1:0]  cnt_q;
  logic           en_q;
  logic           frame_end;
  logic           len_ok;
  logic           par_ok;

  assign frame_end = run_i & ~cfg_en_i & en_q;
  assign len_ok    = (cnt_q == CW'(LEN));

`ifdef DES_SEL_PARITY_EN
  assign par_ok  = ~^sr_q;
  assign frame_o = sr_q[LEN-1:1];
`else
  assign par_ok  = 1'b1;
  assign frame_o = sr_q;
`endif

  assign frame_valid_o = frame_end & len_ok & par_ok;
  assign frame_bad_o   = frame_end & ~(len_ok & par_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= cfg_en_i;
      if (frame_end) begin
        cnt_q <= '0;
      end else if (run_i && cfg_en_i) begin
        sr_q <= {sr_q[LEN-2:0], cfg_data_i};
        // Saturate one past the legal length so overlong frames stay bad.
        if (cnt_q != CW'(LEN + 1)) cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/design_sel_ctrl.sv
// Design-mux select controller: serial reselect, reset and settle sequencing.
// Build with DES_SEL_PARITY_EN to require an even-parity bit per frame.
module design_sel_ctrl
  import design_sel_pkg::*;
#(
  parameter int unsigned SEL_W         = 6,
  parameter int unsigned DEFAULT_SEL   = 0,
  parameter int unsigned RST_CYCLES    = 5,
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_data,
  output logic [SEL_W-1:0] des_sel,
  output logic             hold_if_not_sel,
  output logic             des_reset,
  output logic             ready,
  output logic             cfg_err
);

  localparam int unsigned CMAX =
    (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             hold_q, hold_d;
  logic             err_q, err_d;
  logic             drst_q, drst_d;
  logic             rdy_q, rdy_d;

  logic             frame_valid;
  logic             frame_bad;
  logic [SEL_W:0]   frame;

  cfg_shift_rx #(
    .SEL_W(SEL_W)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .run_i        (state_q == RUN),
    .cfg_en_i     (cfg_en),
    .cfg_data_i   (cfg_data),
    .frame_valid_o(frame_valid),
    .frame_bad_o  (frame_bad),
    .frame_o      (frame)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    err_d   = err_q;
    unique case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        unique case (1'b1)
          frame_valid: begin
            sel_d   = frame[SEL_W-1:0];
            hold_d  = frame[SEL_W];
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = RST_HOLD;
          end
          frame_bad: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = RST_HOLD;
    endcase
    drst_d = (state_d == RST_HOLD);
    rdy_d  = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      sel_q   <= SEL_W'(DEFAULT_SEL);
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      drst_q  <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      drst_q  <= drst_d;
      rdy_q   <= rdy_d;
    end
  end

  assign des_sel         = sel_q;
  assign hold_if_not_sel = hold_q;
  assign des_reset       = drst_q;
  assign ready           = rdy_q;
  assign cfg_err         = err_q;

endmodule

// File: tb/tb_design_sel_ctrl.sv
// Self-checking bench for design_sel_ctrl (default parameters).
// Parity vectors are used when DES_SEL_PARITY_EN is defined.
module tb_design_sel_ctrl;

  localparam int RST = 5;
  localparam int SET = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_en;
  logic       cfg_data;
  logic [5:0] des_sel;
  logic       hold_if_not_sel;
  logic       des_reset;
  logic       ready;
  logic       cfg_err;

  design_sel_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_en         (cfg_en),
    .cfg_data       (cfg_data),
    .des_sel        (des_sel),
    .hold_if_not_sel(hold_if_not_sel),
    .des_reset      (des_reset),
    .ready          (ready),
    .cfg_err        (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [5:0] sel;
    logic       hold;
    logic       drst;
    logic       rdy;
    logic       err;
  } exp_t;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] bits;
    logic        sw;
    logic [5:0]  sel;
    logic        hold;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [5:0] cur_sel;
  logic       cur_hold;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string nm, input logic [5:0] s, input logic h,
                      input logic dr, input logic rd, input logic er);
    exp_t e;
    e.name = nm; e.sel = s; e.hold = h;
    e.drst = dr; e.rdy = rd; e.err = er;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (des_sel !== e.sel || hold_if_not_sel !== e.hold ||
          des_reset !== e.drst || ready !== e.rdy || cfg_err !== e.err) begin
        n_bad++;
        $display("FAIL %s: got sel=%0d hold=%b drst=%b rdy=%b err=%b, want sel=%0d hold=%b drst=%b rdy=%b err=%b",
                 e.name, des_sel, hold_if_not_sel, des_reset, ready, cfg_err,
                 e.sel, e.hold, e.drst, e.rdy, e.err);
      end
    end
  endtask

  // Starts right after the edge that entered RST_HOLD with counter 0.
  task automatic seq_run(input string nm, input logic [5:0] s,
                         input logic h, input logic er);
    for (int k = 1; k <= RST + SET; k++) begin
      step();
      if (k == RST - 1 || k == RST || k == RST + SET - 1 || k == RST + SET) begin
        push($sformatf("%s_c%0d", nm, k), s, h, k < RST, k == RST + SET, er);
        drain();
      end
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en   = 1'b1;
      cfg_data = bits[i];
      step();
    end
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    step();
  endtask

  initial begin
`ifdef DES_SEL_PARITY_EN
    vecs[0] = '{"p_sel5h",  8, 16'b10001011, 1'b1, 6'd5, 1'b1};
    vecs[1] = '{"p_short4", 4, 16'b1010,     1'b0, 6'd0, 1'b0};
    vecs[2] = '{"p_sel3",   8, 16'b00000110, 1'b1, 6'd3, 1'b0};
    vecs[3] = '{"p_badpar", 8, 16'b00000111, 1'b0, 6'd0, 1'b0};
    vecs[4] = '{"p_len7",   7, 16'b0000101,  1'b0, 6'd0, 1'b0};
    vecs[5] = '{"p_sel63",  8, 16'b01111110, 1'b1, 6'd63, 1'b0};
`else
    vecs[0] = '{"sel5h",  7, 16'b1000101,   1'b1, 6'd5, 1'b1};
    vecs[1] = '{"short4", 4, 16'b1010,      1'b0, 6'd0, 1'b0};
    vecs[2] = '{"sel3",   7, 16'b0000011,   1'b1, 6'd3, 1'b0};
    vecs[3] = '{"long9",  9, 16'b000000101, 1'b0, 6'd0, 1'b0};
    vecs[4] = '{"resel3", 7, 16'b0000011,   1'b1, 6'd3, 1'b0};
    vecs[5] = '{"sel63",  7, 16'b0111111,   1'b1, 6'd63, 1'b0};
`endif

    reset    = 1'b1;
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    repeat (5) step();
    push("reset_vals", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    reset = 1'b0;
    seq_run("release", 6'd0, 1'b0, 1'b0);
    cur_sel  = 6'd0;
    cur_hold = 1'b0;

    for (int v = 0; v < 6; v++) begin
      send_bits(vecs[v].bits, vecs[v].n);
      if (vecs[v].sw) begin
        cur_sel  = vecs[v].sel;
        cur_hold = vecs[v].hold;
        push({vecs[v].name, "_latch"}, cur_sel, cur_hold, 1'b1, 1'b0, 1'b0);
        drain();
        seq_run(vecs[v].name, cur_sel, cur_hold, 1'b0);
      end else begin
        push({vecs[v].name, "_rej"}, cur_sel, cur_hold, 1'b0, 1'b1, 1'b1);
        drain();
      end
    end

    // Select 9, then pulse a full frame while busy: must be ignored.
`ifdef DES_SEL_PARITY_EN
    send_bits(16'b00010010, 8);
`else
    send_bits(16'b0001001, 7);
`endif
    push("sel9_latch", 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
`ifdef DES_SEL_PARITY_EN
    send_bits(16'b10000010, 8);
    step();
`else
    send_bits(16'b1000001, 7);
    step();
    step();
`endif
    push("busy_ign", 6'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Frame straddling SETTLE -> RUN only counts bits seen in RUN.
`ifdef DES_SEL_PARITY_EN
    send_bits(16'b00010010, 8);
`else
    send_bits(16'b0001001, 7);
`endif
    repeat (7) step();
    send_bits(16'b0000010, 7);
    push("straddle", 6'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Reselect 9, reset during SETTLE with a dangling frame strobe.
`ifdef DES_SEL_PARITY_EN
    send_bits(16'b00010010, 8);
`else
    send_bits(16'b0001001, 7);
`endif
    repeat (RST + 1) step();
    push("in_settle", 6'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    cfg_en   = 1'b1;
    cfg_data = 1'b1;
    reset    = 1'b1;
    step();
    push("mid_reset", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    reset    = 1'b0;
    seq_run("rerelease", 6'd0, 1'b0, 1'b0);

    // Partial frame then reset mid-frame; next frame must start clean.
    cfg_en = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    cfg_en = 1'b0;
    reset  = 1'b0;
    seq_run("rel2", 6'd0, 1'b0, 1'b0);
`ifdef DES_SEL_PARITY_EN
    send_bits(16'b00000101, 8);
`else
    send_bits(16'b0000010, 7);
`endif
    push("after_discard", 6'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
